// File: rtl/psmac_feeder_if.sv
// Operand/handshake bundle between the element source, the psmac_feeder and the accumulator.
// err_range exists only when PSMAC_FEEDER_RANGECHK_EN is defined.
interface psmac_feeder_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       cfg_mode;
  logic             cfg_sa;
  logic             cfg_sb;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       mr;
  logic [7:0]       md;
  logic [3:0]       sx;
  logic [3:0]       sy;
  logic [1:0]       mode;
  logic             out_last;
  logic [CNT_W-1:0] word_cnt;
`ifdef PSMAC_FEEDER_RANGECHK_EN
  logic             err_range;
`endif

  modport master (
`ifdef PSMAC_FEEDER_RANGECHK_EN
    input  err_range,
`endif
    output cfg_mode, cfg_sa, cfg_sb,
    output in_valid, in_a, in_b, in_last,
    input  in_ready,
    input  out_valid, mr, md, sx, sy, mode, out_last, word_cnt,
    output out_ready
  );

  modport slave (
`ifdef PSMAC_FEEDER_RANGECHK_EN
    output err_range,
`endif
    input  cfg_mode, cfg_sa, cfg_sb,
    input  in_valid, in_a, in_b, in_last,
    output in_ready,
    output out_valid, mr, md, sx, sy, mode, out_last, word_cnt,
    input  out_ready
  );
endinterface

// File: rtl/psmac_feeder.sv
// Packs activation/weight element pairs into 8-bit precision-scalable MAC operand words.
// Optional range checking (err_range) is enabled with `define PSMAC_FEEDER_RANGECHK_EN.
module psmac_feeder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  psmac_feeder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [1:0]       mode_q, mode_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [7:0]       stg_a_q, stg_a_d;
  logic [7:0]       stg_b_q, stg_b_d;
  logic [7:0]       mr_q, mr_d;
  logic [7:0]       md_q, md_d;
  logic [3:0]       sx_q, sx_d;
  logic [3:0]       sy_q, sy_d;
  logic [1:0]       omode_q, omode_d;
  logic             olast_q, olast_d;
  logic             ovalid_q, ovalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready;
  logic             beat;
  logic [1:0]       bmode;
  logic [1:0]       blane;
  logic             bsa;
  logic             bsb;
  logic [7:0]       base_a;
  logic [7:0]       base_b;
  logic [7:0]       pa;
  logic [7:0]       pb;
  logic             close;

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  function automatic logic [1:0] last_lane(input logic [1:0] m);
    case (m)
      2'b01:   return 2'd1;
      2'b10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] place(input logic [7:0] word, input logic [7:0] elem,
                                       input logic [1:0] lane, input logic [1:0] m);
    logic [7:0] w;
    w = word;
    case (m)
      2'b01:   w[{lane[0], 2'b00} +: 4] = elem[3:0];
      2'b10:   w[{lane, 1'b0} +: 2]     = elem[1:0];
      default: w                        = elem;
    endcase
    return w;
  endfunction

  // One flag per 2-bit slice, set on the slice holding each lane's MSB.
  function automatic logic [3:0] sflags(input logic [1:0] m, input logic s);
    logic [3:0] p;
    case (m)
      2'b01:   p = 4'b1010;
      2'b10:   p = 4'b1111;
      default: p = 4'b1000;
    endcase
    return s ? p : 4'b0000;
  endfunction

  always_comb begin
    in_ready = rst_n && (state_q != ISSUE);
    beat     = bus.in_valid && in_ready;

    // The first beat of a vector takes configuration straight from cfg_*; later beats use the latched copy.
    if (state_q == IDLE) begin
      bmode  = eff_mode(bus.cfg_mode);
      bsa    = bus.cfg_sa;
      bsb    = bus.cfg_sb;
      blane  = '0;
      base_a = '0;
      base_b = '0;
    end else begin
      bmode  = mode_q;
      bsa    = sa_q;
      bsb    = sb_q;
      blane  = lane_q;
      base_a = stg_a_q;
      base_b = stg_b_q;
    end
    pa    = place(base_a, bus.in_a, blane, bmode);
    pb    = place(base_b, bus.in_b, blane, bmode);
    close = bus.in_last || (blane == last_lane(bmode));

    state_d  = state_q;
    lane_d   = lane_q;
    mode_d   = mode_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    stg_a_d  = stg_a_q;
    stg_b_d  = stg_b_q;
    mr_d     = mr_q;
    md_d     = md_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    omode_d  = omode_q;
    olast_d  = olast_q;
    ovalid_d = ovalid_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE, PACK: begin
        if (beat) begin
          mode_d = bmode;
          sa_d   = bsa;
          sb_d   = bsb;
          if (close) begin
            mr_d     = pa;
            md_d     = pb;
            sx_d     = sflags(bmode, bsa);
            sy_d     = sflags(bmode, bsb);
            omode_d  = bmode;
            olast_d  = bus.in_last;
            ovalid_d = 1'b1;
            stg_a_d  = '0;
            stg_b_d  = '0;
            lane_d   = '0;
            state_d  = ISSUE;
          end else begin
            stg_a_d = pa;
            stg_b_d = pb;
            lane_d  = blane + 2'd1;
            state_d = PACK;
          end
        end
      end
      ISSUE: begin
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          if (olast_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            lane_d  = '0;
            state_d = PACK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      mode_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      stg_a_q  <= '0;
      stg_b_q  <= '0;
      mr_q     <= '0;
      md_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      omode_q  <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      mode_q   <= mode_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      stg_a_q  <= stg_a_d;
      stg_b_q  <= stg_b_d;
      mr_q     <= mr_d;
      md_q     <= md_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      omode_q  <= omode_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ovalid_q;
  assign bus.mr        = mr_q;
  assign bus.md        = md_q;
  assign bus.sx        = sx_q;
  assign bus.sy        = sy_q;
  assign bus.mode      = omode_q;
  assign bus.out_last  = olast_q;
  assign bus.word_cnt  = cnt_q;

`ifdef PSMAC_FEEDER_RANGECHK_EN
  logic err_q, err_d;

  // An element fits W bits when its discarded upper bits are zero (unsigned) or a pure sign extension (signed).
  function automatic logic oor(input logic [7:0] e, input logic s, input logic [1:0] m);
    case (m)
      2'b01:   return s ? !((e[7:3] == '0) || (e[7:3] == '1)) : (e[7:4] != '0);
      2'b10:   return s ? !((e[7:1] == '0) || (e[7:1] == '1)) : (e[7:2] != '0);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    err_d = err_q;
    if (beat && (oor(bus.in_a, bsa, bmode) || oor(bus.in_b, bsb, bmode))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_range = err_q;
`endif

endmodule

// File: tb/tb_psmac_feeder.sv
// Self-checking bench for psmac_feeder: directed vector table, multi-cycle sequences, randomized model check.
module tb_psmac_feeder;

  logic clk;
  logic rst_n;
  logic man_ready;
  logic rnd_ready;
  logic mon_en;
  int unsigned tests;
  int unsigned fails;

  psmac_feeder_if #(.CNT_W(16)) bus ();

  psmac_feeder #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.out_ready = mon_en ? rnd_ready : man_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic             sa;
    logic             sb;
    int unsigned      n;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [7:0]       mr;
    logic [7:0]       md;
    logic [3:0]       sx;
    logic [3:0]       sy;
  } vec_t;

  typedef struct {
    logic [7:0]  mr;
    logic [7:0]  md;
    logic [3:0]  sx;
    logic [3:0]  sy;
    logic [1:0]  mode;
    logic        last;
    logic [15:0] cnt;
  } word_t;

  word_t      exp_q[$];
  word_t      mon_w;
  vec_t       tbl[7];
  logic [7:0] ra[16];
  logic [7:0] rb[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int unsigned g;
    g = 0;
    while (!bus.in_ready && g < 200) begin
      tick();
      g++;
    end
    if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] mode, input logic sa, input logic sb,
                              input int unsigned n, input logic [31:0] a, input logic [31:0] b,
                              input logic [7:0] mr, input logic [7:0] md,
                              input logic [3:0] sx, input logic [3:0] sy);
    vec_t v;
    v.mode = mode; v.sa = sa; v.sb = sb; v.n = n;
    v.a = a; v.b = b; v.mr = mr; v.md = md; v.sx = sx; v.sy = sy;
    return v;
  endfunction

  // Reference: word j holds elements j*L .. j*L+L-1, element k at bit k*W, truncated to W bits.
  task automatic build_model(input int unsigned m, input logic sa, input logic sb, input int unsigned n);
    int unsigned L, W, nw, p, acca, accb, idx;
    word_t w;
    L  = (m == 1) ? 2 : (m == 2) ? 4 : 1;
    W  = 8 / L;
    nw = (n + L - 1) / L;
    p  = 0;
    for (int unsigned k = 0; k < L; k++) p = p | (1 << ((k * W + W - 1) / 2));
    for (int unsigned j = 0; j < nw; j++) begin
      acca = 0;
      accb = 0;
      for (int unsigned k = 0; k < L; k++) begin
        idx = j * L + k;
        if (idx < n) begin
          acca = acca + ((32'(ra[idx]) % (1 << W)) << (k * W));
          accb = accb + ((32'(rb[idx]) % (1 << W)) << (k * W));
        end
      end
      w.mr   = acca[7:0];
      w.md   = accb[7:0];
      w.sx   = sa ? p[3:0] : 4'b0000;
      w.sy   = sb ? p[3:0] : 4'b0000;
      w.mode = (m == 3) ? 2'b00 : 2'(m);
      w.last = (j == nw - 1);
      w.cnt  = 16'(j);
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      rnd_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && rnd_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_w = exp_q.pop_front();
          chk("rnd_mr", 32'(bus.mr), 32'(mon_w.mr));
          chk("rnd_md", 32'(bus.md), 32'(mon_w.md));
          chk("rnd_sx", 32'(bus.sx), 32'(mon_w.sx));
          chk("rnd_sy", 32'(bus.sy), 32'(mon_w.sy));
          chk("rnd_mode", 32'(bus.mode), 32'(mon_w.mode));
          chk("rnd_last", 32'(bus.out_last), 32'(mon_w.last));
          chk("rnd_cnt", 32'(bus.word_cnt), 32'(mon_w.cnt));
        end
      end
    end else begin
      rnd_ready = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned m, n, g;
    logic sa, sb;
    logic [7:0] s_mr, s_md;

    tests = 0; fails = 0;
    mon_en = 1'b0; man_ready = 1'b0;
    rst_n = 1'b0;
    bus.cfg_mode = 2'b00; bus.cfg_sa = 1'b0; bus.cfg_sb = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.in_last = 1'b1;

    // Reset with in_valid held high
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mr", 32'(bus.mr), 32'h00);
    chk("rst_md", 32'(bus.md), 32'h00);
    chk("rst_sx", 32'(bus.sx), 32'h0);
    chk("rst_sy", 32'(bus.sy), 32'h0);
    chk("rst_cnt", 32'(bus.word_cnt), 32'd0);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    tbl[0] = mk(2'd0, 1'b1, 1'b1, 1, 32'h000000F6, 32'h00000003, 8'hF6, 8'h03, 4'b1000, 4'b1000);
    tbl[1] = mk(2'd1, 1'b0, 1'b0, 2, 32'h00000503, 32'h00000702, 8'h53, 8'h72, 4'b0000, 4'b0000);
    tbl[2] = mk(2'd2, 1'b1, 1'b0, 3, 32'h00020301, 32'h00000000, 8'h2D, 8'h00, 4'b1111, 4'b0000);
    tbl[3] = mk(2'd3, 1'b0, 1'b1, 1, 32'h000000A5, 32'h0000005A, 8'hA5, 8'h5A, 4'b0000, 4'b1000);
    tbl[4] = mk(2'd1, 1'b1, 1'b1, 2, 32'h0000081F, 32'h00003412, 8'h8F, 8'h42, 4'b1010, 4'b1010);
    tbl[5] = mk(2'd2, 1'b0, 1'b1, 4, 32'h00010203, 32'hFFFFFFFF, 8'h1B, 8'hFF, 4'b0000, 4'b1111);
    tbl[6] = mk(2'd1, 1'b1, 1'b0, 1, 32'h00000006, 32'h00000009, 8'h06, 8'h09, 4'b1010, 4'b0000);

    for (int t = 0; t < 7; t++) begin
      bus.cfg_mode = tbl[t].mode; bus.cfg_sa = tbl[t].sa; bus.cfg_sb = tbl[t].sb;
      for (int unsigned i = 0; i < tbl[t].n; i++) begin
        send(tbl[t].a[i], tbl[t].b[i], i == tbl[t].n - 1);
        // cfg changes after the first beat must not affect the vector
        bus.cfg_mode = ~tbl[t].mode; bus.cfg_sa = ~tbl[t].sa; bus.cfg_sb = ~tbl[t].sb;
      end
      chk($sformatf("t%0d_valid", t), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t%0d_mr", t), 32'(bus.mr), 32'(tbl[t].mr));
      chk($sformatf("t%0d_md", t), 32'(bus.md), 32'(tbl[t].md));
      chk($sformatf("t%0d_sx", t), 32'(bus.sx), 32'(tbl[t].sx));
      chk($sformatf("t%0d_sy", t), 32'(bus.sy), 32'(tbl[t].sy));
      chk($sformatf("t%0d_mode", t), 32'(bus.mode), (tbl[t].mode == 2'b11) ? 32'd0 : 32'(tbl[t].mode));
      chk($sformatf("t%0d_last", t), 32'(bus.out_last), 32'd1);
      chk($sformatf("t%0d_cnt", t), 32'(bus.word_cnt), 32'd0);
      man_ready = 1'b1; tick(); man_ready = 1'b0;
      chk($sformatf("t%0d_idle_rdy", t), 32'(bus.in_ready), 32'd1);
      chk($sformatf("t%0d_idle_vld", t), 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: two 2b words, word 0 stalled for three cycles
    bus.cfg_mode = 2'b10; bus.cfg_sa = 1'b0; bus.cfg_sb = 1'b0;
    ra[0] = 8'd1; ra[1] = 8'd2; ra[2] = 8'd3; ra[3] = 8'd0;
    ra[4] = 8'd3; ra[5] = 8'd3; ra[6] = 8'd2; ra[7] = 8'd1;
    for (int i = 0; i < 8; i++) rb[i] = (i < 4) ? 8'(i) : 8'd0;
    for (int i = 0; i < 4; i++) send(ra[i], rb[i], 1'b0);
    chk("bp_valid0", 32'(bus.out_valid), 32'd1);
    s_mr = bus.mr; s_md = bus.md;
    chk("bp_mr0", 32'(s_mr), 32'h39);
    chk("bp_md0", 32'(s_md), 32'hE4);
    chk("bp_last0", 32'(bus.out_last), 32'd0);
    bus.in_valid = 1'b1; bus.in_a = ra[4]; bus.in_b = rb[4]; bus.in_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_stall_rdy", 32'(bus.in_ready), 32'd0);
      chk("bp_stall_mr", 32'(bus.mr), 32'(s_mr));
      chk("bp_stall_md", 32'(bus.md), 32'(s_md));
    end
    man_ready = 1'b1; tick(); man_ready = 1'b0;
    chk("bp_cnt1", 32'(bus.word_cnt), 32'd1);
    chk("bp_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_hs_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 5; i < 8; i++) send(ra[i], rb[i], i == 7);
    chk("bp_valid1", 32'(bus.out_valid), 32'd1);
    chk("bp_mr1", 32'(bus.mr), 32'h6F);
    chk("bp_md1", 32'(bus.md), 32'h00);
    chk("bp_cnt_w1", 32'(bus.word_cnt), 32'd1);
    chk("bp_last1", 32'(bus.out_last), 32'd1);
    man_ready = 1'b1; tick(); man_ready = 1'b0;
    chk("bp_cnt_clr", 32'(bus.word_cnt), 32'd0);
    chk("bp_end_rdy", 32'(bus.in_ready), 32'd1);

    // Reset while a word is pending
    bus.cfg_mode = 2'b01; bus.cfg_sa = 1'b0; bus.cfg_sb = 1'b0;
    send(8'd1, 8'd1, 1'b1);
    chk("rmid_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rmid_drop", 32'(bus.out_valid), 32'd0);
    chk("rmid_rdy", 32'(bus.in_ready), 32'd0);
    chk("rmid_mr", 32'(bus.mr), 32'h00);
    rst_n = 1'b1;
    bus.cfg_mode = 2'b00; bus.cfg_sa = 1'b1; bus.cfg_sb = 1'b0;
    #1;
    send(8'h7E, 8'h81, 1'b1);
    chk("rnew_valid", 32'(bus.out_valid), 32'd1);
    chk("rnew_mr", 32'(bus.mr), 32'h7E);
    chk("rnew_md", 32'(bus.md), 32'h81);
    chk("rnew_mode", 32'(bus.mode), 32'd0);
    chk("rnew_sx", 32'(bus.sx), 32'h8);
    chk("rnew_sy", 32'(bus.sy), 32'h0);
    chk("rnew_cnt", 32'(bus.word_cnt), 32'd0);
    man_ready = 1'b1; tick(); man_ready = 1'b0;

    // Randomized vectors against the packing model with random backpressure
    mon_en = 1'b1;
    for (int v = 0; v < 60; v++) begin
      m  = $urandom_range(0, 3);
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 9);
      for (int unsigned i = 0; i < n; i++) begin
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
      end
      build_model(m, sa, sb, n);
      bus.cfg_mode = 2'(m); bus.cfg_sa = sa; bus.cfg_sb = sb;
      for (int unsigned i = 0; i < n; i++) begin
        g = $urandom_range(0, 2);
        for (int unsigned k = 0; k < g; k++) tick();
        send(ra[i], rb[i], i == n - 1);
        bus.cfg_mode = 2'($urandom); bus.cfg_sa = 1'($urandom); bus.cfg_sb = 1'($urandom);
      end
      g = 0;
      while (exp_q.size() != 0 && g < 500) begin
        tick();
        g++;
      end
      if (exp_q.size() != 0) begin
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
      tick();
      chk("rnd_cnt_clr", 32'(bus.word_cnt), 32'd0);
      chk("rnd_idle_rdy", 32'(bus.in_ready), 32'd1);
    end
    mon_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
